// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state, parameter legality check and truncation column mask
package mult_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int MAX_W = 64;
   function automatic logic step_bits_ok(input int s);
      return s == 1 || s == 2 || s == 4;
   endfunction
   // bit p is kept when its product column p + lo_col reaches trunc
   function automatic logic [MAX_W-1:0] col_mask(input int lo_col, input int trunc);
      logic [MAX_W-1:0] m;
      for (int p = 0; p < MAX_W; p++) m[p] = p + lo_col >= trunc;
      return m;
   endfunction
endpackage

// File: rtl/approx_pp_step.sv
// approx_pp_step: one iteration's masked, shifted partial product (combinational)
//  a       in   WIDTH      multiplicand
//  b_slice in   STEP_BITS  multiplier bits consumed this step
//  step    in   CW         step index k; slice bit m sits at column k*STEP_BITS+m
//  approx  in   1          drop partial-product bits in columns below TRUNC
//  pp      out  2*WIDTH    sum of a*b_slice[m] << column, masked in approx mode
module approx_pp_step
   import mult_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int STEP_BITS = 1,
   parameter int TRUNC     = 8,
   parameter int CW        = 4
) (
   input  logic [WIDTH-1:0]     a,
   input  logic [STEP_BITS-1:0] b_slice,
   input  logic [CW-1:0]        step,
   input  logic                 approx,
   output logic [2*WIDTH-1:0]   pp
);
   logic [WIDTH-1:0] am [STEP_BITS];
   for (genvar g = 0; g < STEP_BITS; g++) begin : g_row
      assign am[g] = approx ? a & WIDTH'(col_mask(int'(step) * STEP_BITS + g, TRUNC)) : a;
   end
   always_comb begin
      pp = '0;
      for (int m = 0; m < STEP_BITS; m++)
         pp = pp + (b_slice[m] ? {{WIDTH{1'b0}}, am[m]} << (int'(step) * STEP_BITS + m) : '0);
   end
endmodule

// File: rtl/approx_mult_iter.sv
// approx_mult_iter: iterative unsigned multiplier with run-time selectable truncation
//  clk, rst              clock, synchronous active-high reset
//  in_valid/in_ready     operand handshake; in_ready high only while idle
//  in_a, in_b, in_approx operands and mode (1 = truncated product)
//  out_valid/out_ready   result handshake; result held until taken
//  out_prod, out_approx  product and the mode it was computed in
module approx_mult_iter
   import mult_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int STEP_BITS = 1,
   parameter int TRUNC     = 8,
   parameter int COMP_EN   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_approx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic                 out_approx
);
   localparam int N  = WIDTH / STEP_BITS;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   // bias compensation for the dropped columns, applied once on the last step
   localparam logic [2*WIDTH-1:0] COMP = (COMP_EN != 0 && TRUNC > 0) ?
      (2*WIDTH)'(1) << (TRUNC > 0 ? TRUNC - 1 : 0) : '0;
   if (!step_bits_ok(STEP_BITS) || WIDTH % STEP_BITS != 0 || WIDTH > MAX_W ||
       TRUNC < 0 || TRUNC > 2*WIDTH - 1) begin : g_bad_params
      $error("approx_mult_iter: illegal WIDTH/STEP_BITS/TRUNC combination");
   end
   state_t               state;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     a_r, b_r;
   logic                 approx_r;
   logic [2*WIDTH-1:0]   acc, pp, sum;
   logic                 last;
   approx_pp_step #(.WIDTH(WIDTH), .STEP_BITS(STEP_BITS), .TRUNC(TRUNC), .CW(CW)) u_pp (
      .a(a_r),
      .b_slice(b_r[STEP_BITS-1:0]),
      .step(cnt),
      .approx(approx_r),
      .pp(pp)
   );
   assign last = cnt == CW'(N - 1);
   assign sum  = acc + pp + ((last && approx_r) ? COMP : '0);
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_prod   <= '0;
         out_approx <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         a_r        <= '0;
         b_r        <= '0;
         approx_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r      <= in_a;
               b_r      <= in_b;
               approx_r <= in_approx;
               acc      <= '0;
               cnt      <= '0;
               in_ready <= 1'b0;
               state    <= RUN;
            end
            RUN: begin
               // the multiplier shifts down so the current slice is always at the bottom
               acc <= sum;
               b_r <= b_r >> STEP_BITS;
               cnt <= cnt + CW'(1);
               if (last) begin
                  cnt        <= '0;
                  out_valid  <= 1'b1;
                  out_prod   <= sum;
                  out_approx <= approx_r;
                  state      <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_approx_mult_iter.sv
// tb_approx_mult_iter: directed and reference-model checks over three parameterisations
module tb_approx_mult_iter;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid [3];
   logic        in_ready [3];
   logic [15:0] in_a [3];
   logic [15:0] in_b [3];
   logic        in_approx [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [31:0] out_prod [3];
   logic        out_approx [3];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   approx_mult_iter #(.WIDTH(16), .STEP_BITS(1), .TRUNC(8), .COMP_EN(0)) d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]),
      .in_b(in_b[0]), .in_approx(in_approx[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_prod(out_prod[0]), .out_approx(out_approx[0]));
   approx_mult_iter #(.WIDTH(16), .STEP_BITS(1), .TRUNC(8), .COMP_EN(1)) d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]),
      .in_b(in_b[1]), .in_approx(in_approx[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_prod(out_prod[1]), .out_approx(out_approx[1]));
   approx_mult_iter #(.WIDTH(16), .STEP_BITS(4), .TRUNC(8), .COMP_EN(0)) d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_a(in_a[2]),
      .in_b(in_b[2]), .in_approx(in_approx[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .out_prod(out_prod[2]), .out_approx(out_approx[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // bit-level truncated product: keep a[i]&b[j] only where column i+j >= 8
   function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                            input logic ap);
      logic [31:0] r = '0;
      if (!ap) return 32'(a) * 32'(b);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            if (i + j >= 8 && a[i] && b[j]) r = r + (32'd1 << (i + j));
      return r;
   endfunction

   // inputs are driven and outputs sampled 1 time unit after each rising edge
   task automatic op(input int d, input logic [15:0] a, input logic [15:0] b, input logic ap,
                     input logic [31:0] exp, input int n, input string tag);
      int lat;
      chk({tag, "_in_ready"}, in_ready[d], 1);
      in_a[d] = a;
      in_b[d] = b;
      in_approx[d] = ap;
      in_valid[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      lat = 0;
      while (!out_valid[d] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, n);
      chk({tag, "_prod"}, out_prod[d], exp);
      chk({tag, "_approx"}, out_approx[d], ap);
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      chk({tag, "_valid_drop"}, out_valid[d], 0);
      chk({tag, "_ready_back"}, in_ready[d], 1);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rap;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0;
         in_a[i] = '0;
         in_b[i] = '0;
         in_approx[i] = 1'b0;
         out_ready[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("reset_in_ready", in_ready[i], 1);
         chk("reset_out_valid", out_valid[i], 0);
         chk("reset_out_prod", out_prod[i], 0);
         chk("reset_out_approx", out_approx[i], 0);
      end

      op(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16, "max_exact");
      op(0, 16'h000F, 16'h000F, 1'b0, 32'h000000E1, 16, "f_by_f_exact");
      op(0, 16'h000F, 16'h000F, 1'b1, 32'h00000000, 16, "f_by_f_approx");
      op(0, 16'h0100, 16'h0001, 1'b1, 32'h00000100, 16, "col8_approx");
      op(0, 16'h0000, 16'h1234, 1'b0, 32'h00000000, 16, "zero_operand");
      op(1, 16'h0100, 16'h0001, 1'b1, 32'h00000180, 16, "col8_comp");
      op(1, 16'h000F, 16'h000F, 1'b1, 32'h00000080, 16, "f_by_f_comp");
      op(1, 16'h000F, 16'h000F, 1'b0, 32'h000000E1, 16, "f_by_f_comp_exact");

      // in_valid stays high with new operands through RUN and DONE: must be ignored
      in_a[0] = 16'h1234;
      in_b[0] = 16'h0010;
      in_approx[0] = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_a[0] = 16'h5555;
      in_b[0] = 16'h7777;
      repeat (16) @(posedge clk);
      #1;
      chk("hold_valid_up", out_valid[0], 1);
      for (int c = 0; c < 5; c++) begin
         chk("hold_prod_stable", out_prod[0], 32'h00012340);
         chk("hold_in_ready_low", in_ready[0], 0);
         @(posedge clk); #1;
      end
      chk("hold_valid_still", out_valid[0], 1);
      chk("hold_prod_final", out_prod[0], 32'h00012340);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      chk("hold_release_valid", out_valid[0], 0);
      chk("hold_release_ready", in_ready[0], 1);

      // reset pulse while at RUN step 7
      in_a[0] = 16'hABCD;
      in_b[0] = 16'hFFFF;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_out_valid", out_valid[0], 0);
      chk("abort_in_ready", in_ready[0], 1);
      chk("abort_out_prod", out_prod[0], 0);
      op(0, 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 16, "after_abort");

      op(2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 4, "s4_max_exact");
      op(2, 16'h000F, 16'h000F, 1'b1, 32'h00000000, 4, "s4_f_by_f_approx");
      op(2, 16'h0100, 16'h0001, 1'b1, 32'h00000100, 4, "s4_col8_approx");
      for (int k = 0; k < 1000; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rap = 1'($urandom_range(0, 1));
         op(2, ra, rb, rap, ref_prod(ra, rb, rap), 4, "s4_random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
